frog_move_encoder: RTL and testbench
====================================

FROG_MOVE_ENCODER -- requirements
Module: frog_move_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, consecutive stable cycles required to accept a switch level change (10 ms at 25 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 12500000, cycles a held switch waits before the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, cycles between later auto-repeats.
REQ-004 SHALL have port clk, input, 1, system clock; the single clock domain.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port switch1..switch4, input, 1 each, raw asynchronous buttons (up, down, left, right).
REQ-007 SHALL have port flush, input, 1, game restart (death/win): drops any pending command.
REQ-008 SHALL have port move_ready, input, 1, consumer (frog) accepts a command.
REQ-009 SHALL have port move_valid, output, 1, a command is pending.
REQ-010 SHALL have port move_dir, output, 2, direction: 0 up, 1 down, 2 left, 3 right (same coding as frog_direction).
REQ-011 SHALL have port sw_state, output, 4, debounced levels; bit0 = switch1.

Function
REQ-012 Each switch SHALL pass through a 2-flop synchronizer before debounce; input-to-debounce latency is 2 cycles.
REQ-013 The debounced level SHALL flip only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears that switch's counter.
REQ-014 A press event SHALL be a debounced 0->1 edge; releases generate no command.
REQ-015 Same-cycle press events SHALL resolve by fixed priority up > down > left > right; losers are discarded.
REQ-016 FSM states SHALL be IDLE, HOLD and REPEAT.
REQ-017 IDLE: on a press event -> HOLD; latch the direction; start the timer at REPEAT_DELAY; issue a command.
REQ-018 HOLD/REPEAT: when the timer expires while the latched switch is still debounced-high -> REPEAT; issue a command; reload the timer with REPEAT_PERIOD.
REQ-019 HOLD/REPEAT: when the latched switch goes debounced-low -> IDLE the next cycle; presses on other switches are ignored until then.
REQ-020 Issuing a command SHALL set move_valid the cycle after the event; move_dir SHALL be driven the same cycle.
REQ-021 move_valid and move_dir SHALL hold stable until a cycle with move_valid && move_ready; move_valid SHALL deassert the following cycle.
REQ-022 A command issued while one is still pending SHALL be dropped; there is no queue and no overwrite.
REQ-023 move_valid SHALL be allowed to rise the cycle after a transfer, giving back-to-back throughput of one command per 2 cycles.
REQ-024 flush SHALL clear move_valid and return the FSM to IDLE next cycle; flush overrides a same-cycle event or transfer; debounce state is kept.
REQ-025 The timer SHALL be 24 bits; values larger than 2^24-1 are illegal parameters.

Reset
REQ-026 While reset is high at a clk edge: move_valid=0, move_dir=0, sw_state=0, FSM=IDLE, all counters and synchronizers 0.
REQ-027 A switch held during reset SHALL produce a press event once DEBOUNCE_CYCLES have elapsed after reset.

Configuration
REQ-028 Macro FROG_AUTO_REPEAT_EN defined: REQ-018 is active.
REQ-029 Macro FROG_AUTO_REPEAT_EN undefined: HOLD never moves to REPEAT; one command per press; the REPEAT_DELAY/REPEAT_PERIOD timer logic is not built.

Structure
REQ-030 The move_dir encoding constants (DIR_UP..DIR_RIGHT) and FSM state constants SHALL reside in the shared game package used by frog.
REQ-031 Debounce SHALL be a sub-module switch_debouncer (synchronizer + counter, one bit), instantiated 4 times.

Verification
REQ-032 DEBOUNCE_CYCLES=4, move_ready=1, switch1 pulsed 3 cycles -> no move_valid, sw_state stays 0.
REQ-033 switch3 held 4+2 cycles -> move_valid for 1 cycle with move_dir=2.
REQ-034 switch1 and switch4 rise same cycle -> exactly one command with move_dir=0.
REQ-035 move_ready=0, press switch2 -> move_valid and move_dir=1 held 20 cycles; raise ready -> valid drops the next cycle.
REQ-036 REPEAT_DELAY=10, REPEAT_PERIOD=5, switch4 held 40 cycles -> commands at press+1, +10, +15, +20 ...; with macro undefined -> a single command.
REQ-037 Pending command with flush and move_ready both high the same cycle -> move_valid=0 next cycle, FSM=IDLE.

Source files
------------

// File: rtl/frog_move_encoder_pkg.sv
// Shared game package: move direction coding and move encoder FSM states.
// These are the same direction constants the frog consumer uses.
package frog_move_encoder_pkg;

  localparam int TIMER_W = 24;
  localparam int NUM_SW  = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } move_state_e;

  // Fixed-priority pick among simultaneous presses: up > down > left > right.
  function automatic dir_e pick_dir(input logic [NUM_SW-1:0] press);
    dir_e d;
    if (press[0])      d = DIR_UP;
    else if (press[1]) d = DIR_DOWN;
    else if (press[2]) d = DIR_LEFT;
    else               d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// One-bit switch conditioner: 2-flop synchronizer followed by a
// consecutive-disagreement counter that flips the debounced level.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0;
  logic             sync1;
  logic [CNT_W-1:0] cnt;

  // Synchronize the raw input, then accept a new level only after it has
  // disagreed with the current one for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      if (sync1 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/frog_move_encoder.sv
// Frog move encoder: four debounced buttons turned into a valid/ready
// command stream (one command per press, single-entry, no queue).
// Optional auto-repeat while a button is held: define FROG_AUTO_REPEAT_EN.
module frog_move_encoder
  import frog_move_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       switch4,
  input  logic       flush,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] sw_state
);

  localparam int TIMER_MAX = (1 << TIMER_W) - 1;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > TIMER_MAX) begin : g_bad_delay
    $error("REPEAT_DELAY must fit the 24-bit repeat timer");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > TIMER_MAX) begin : g_bad_period
    $error("REPEAT_PERIOD must fit the 24-bit repeat timer");
  end

  logic [NUM_SW-1:0] sw_raw;
  logic [NUM_SW-1:0] sw_prev;
  logic [NUM_SW-1:0] press;
  move_state_e       state;
  move_state_e       state_next;
  dir_e              held;
  dir_e              held_next;
  logic              issue;

  assign sw_raw = {switch4, switch3, switch2, switch1};

  for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
    switch_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (sw_raw[i]),
      .level(sw_state[i])
    );
  end

  // A press is a debounced rising edge; releases are not events.
  assign press = sw_state & ~sw_prev;

`ifdef FROG_AUTO_REPEAT_EN
  // The timer is loaded with N-1 and a command fires when it reads zero,
  // so consecutive commands land exactly N cycles apart.
  localparam logic [TIMER_W-1:0] DELAY_LOAD  = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] PERIOD_LOAD = TIMER_W'(REPEAT_PERIOD - 1);

  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;

  // Repeat timer register.
  always_ff @(posedge clk) begin
    if (reset) timer <= '0;
    else       timer <= timer_next;
  end
`endif

  // FSM state, latched direction and edge-detect history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      held    <= DIR_UP;
      sw_prev <= '0;
    end else begin
      state   <= state_next;
      held    <= held_next;
      sw_prev <= sw_state;
    end
  end

  // Next-state logic: press starts a hold, release returns to idle, timer fires repeats.
  always_comb begin
    state_next = state;
    held_next  = held;
    issue      = 1'b0;
`ifdef FROG_AUTO_REPEAT_EN
    timer_next = timer;
`endif
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (|press) begin
            state_next = HOLD;
            held_next  = pick_dir(press);
            issue      = 1'b1;
`ifdef FROG_AUTO_REPEAT_EN
            timer_next = DELAY_LOAD;
`endif
          end
        end
        HOLD, REPEAT: begin
          if (!sw_state[held]) begin
            state_next = IDLE;
          end
`ifdef FROG_AUTO_REPEAT_EN
          else if (timer == '0) begin
            state_next = REPEAT;
            issue      = 1'b1;
            timer_next = PERIOD_LOAD;
          end else begin
            timer_next = timer - TIMER_W'(1);
          end
`endif
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Single-entry command slot: a new command only lands in an empty slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      move_valid <= 1'b0;
      move_dir   <= DIR_UP;
    end else if (flush) begin
      move_valid <= 1'b0;
    end else if (!move_valid && issue) begin
      move_valid <= 1'b1;
      move_dir   <= held_next;
    end else if (move_valid && move_ready) begin
      move_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frog_move_encoder.sv
// Testbench for frog_move_encoder: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a
// behavioural model. Honors FROG_AUTO_REPEAT_EN like the design.
module tb_frog_move_encoder;

  localparam int DEB     = 4;
  localparam int RDELAY  = 10;
  localparam int RPERIOD = 5;
`ifdef FROG_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       switch1 = 1'b0;
  logic       switch2 = 1'b0;
  logic       switch3 = 1'b0;
  logic       switch4 = 1'b0;
  logic       flush = 1'b0;
  logic       move_ready = 1'b1;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [3:0] sw_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frog_move_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDELAY),
    .REPEAT_PERIOD  (RPERIOD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .switch1   (switch1),
    .switch2   (switch2),
    .switch3   (switch3),
    .switch4   (switch4),
    .flush     (flush),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .sw_state  (sw_state)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Called at a negedge; holds the inputs for the given number of clock edges.
  task automatic applyStimulus(input logic [3:0] sw, input logic rdy, input logic fl, input int cycles);
    {switch4, switch3, switch2, switch1} = sw;
    move_ready = rdy;
    flush      = fl;
    repeat (cycles) @(negedge clk);
  endtask

  // Behavioural model: each button's synchronized value is its raw value
  // two edges ago; the level flips after DEB consecutive disagreeing edges.
  // Commands are tracked as absolute cycle numbers for repeat scheduling.
  logic [3:0] m_d1, m_d2, m_lvl, m_rose;
  int         m_run [4];
  bit         m_hold;
  int         m_held;
  int         m_next;
  int         m_cyc;
  bit         m_issue;
  logic       m_valid;
  logic [1:0] m_dir;

  // Advance the model by one clock edge using the inputs seen at that edge.
  always @(posedge clk) begin
    if (reset) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_rose = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_hold = 0; m_held = 0; m_next = 0; m_cyc = 0;
      m_valid = 1'b0; m_dir = 2'd0;
    end else begin
      m_issue = 0;
      if (flush) begin
        m_hold  = 0;
        m_valid = 1'b0;
      end else begin
        if (!m_hold) begin
          for (int i = 0; i < 4; i++) begin
            if (m_rose[i] && !m_issue) begin
              m_issue = 1; m_hold = 1; m_held = i; m_next = m_cyc + RDELAY;
            end
          end
        end else if (!m_lvl[m_held]) begin
          m_hold = 0;
        end else if (AUTO && m_cyc == m_next) begin
          m_issue = 1; m_next = m_cyc + RPERIOD;
        end
        if (!m_valid && m_issue) begin
          m_valid = 1'b1;
          m_dir   = m_held[1:0];
        end else if (m_valid && move_ready) begin
          m_valid = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        m_rose[i] = 1'b0;
        if (m_d2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl[i]  = m_d2[i];
            m_run[i]  = 0;
            m_rose[i] = m_lvl[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = {switch4, switch3, switch2, switch1};
      m_cyc++;
    end
  end

  int         tb_cyc = 0;
  int         cmd_count = 0;
  logic [1:0] cmd_dir = 2'd0;
  int         cmd_times [$];
  logic       last_valid = 1'b0;
  logic [3:0] sw_or = '0;

  // Compare DUT against the model one time unit after each edge and log commands.
  always @(posedge clk) begin
    #1;
    tb_cyc++;
    if (!reset) begin
      checkOutput("move_valid", move_valid, m_valid);
      checkOutput("move_dir", move_dir, m_dir);
      checkOutput("sw_state", sw_state, m_lvl);
      sw_or |= sw_state;
      if (move_valid && (!last_valid || move_ready)) begin
        cmd_count++;
        cmd_dir = move_dir;
        cmd_times.push_back(tb_cyc);
      end
    end
    last_valid = move_valid;
  end

  int c0;
  int stable;

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", move_valid, 0);
    checkOutput("reset_dir", move_dir, 0);
    checkOutput("reset_sw_state", sw_state, 0);
    reset = 1'b0;
    applyStimulus(4'b0000, 1'b1, 1'b0, 5);

    // Short glitch never reaches the debounced level.
    sw_or = '0;
    c0 = cmd_count;
    applyStimulus(4'b0001, 1'b1, 1'b0, 3);
    applyStimulus(4'b0000, 1'b1, 1'b0, 12);
    checkOutput("glitch_cmds", cmd_count - c0, 0);
    checkOutput("glitch_sw_state", sw_or, 0);

    // Left held just long enough: one command, direction 2.
    c0 = cmd_count;
    applyStimulus(4'b0100, 1'b1, 1'b0, 6);
    applyStimulus(4'b0000, 1'b1, 1'b0, 15);
    checkOutput("left_cmds", cmd_count - c0, 1);
    checkOutput("left_dir", cmd_dir, 2);

    // Up and right together: up wins, right discarded.
    c0 = cmd_count;
    applyStimulus(4'b1001, 1'b1, 1'b0, 8);
    applyStimulus(4'b0000, 1'b1, 1'b0, 15);
    checkOutput("prio_cmds", cmd_count - c0, 1);
    checkOutput("prio_dir", cmd_dir, 0);

    // Back-pressure: down command held while ready is low.
    applyStimulus(4'b0010, 1'b0, 1'b0, 10);
    checkOutput("stall_valid", move_valid, 1);
    checkOutput("stall_dir", move_dir, 1);
    stable = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(4'b0010, 1'b0, 1'b0, 1);
      if (move_valid === 1'b1 && move_dir === 2'd1) stable++;
    end
    checkOutput("stall_hold20", stable, 20);
    applyStimulus(4'b0010, 1'b1, 1'b0, 1);
    checkOutput("stall_release_valid", move_valid, 0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 20);

    // Right held 40 cycles: repeats when enabled, single command otherwise.
    c0 = cmd_count;
    applyStimulus(4'b1000, 1'b1, 1'b0, 40);
    applyStimulus(4'b0000, 1'b1, 1'b0, 20);
    checkOutput("repeat_cmds", cmd_count - c0, AUTO ? 7 : 1);
    checkOutput("repeat_dir", cmd_dir, 3);
`ifdef FROG_AUTO_REPEAT_EN
    if (cmd_times.size() >= c0 + 3) begin
      checkOutput("repeat_gap_first", cmd_times[c0+1] - cmd_times[c0], RDELAY);
      checkOutput("repeat_gap_next", cmd_times[c0+2] - cmd_times[c0+1], RPERIOD);
    end else begin
      checkOutput("repeat_gap_count", cmd_times.size() - c0, 3);
    end
`endif

    // Flush with ready in the same cycle drops the command and idles the FSM.
    applyStimulus(4'b0010, 1'b0, 1'b0, 10);
    checkOutput("flush_pre_valid", move_valid, 1);
    applyStimulus(4'b0010, 1'b1, 1'b1, 1);
    checkOutput("flush_valid", move_valid, 0);
    c0 = cmd_count;
    applyStimulus(4'b0010, 1'b1, 1'b0, 30);
    checkOutput("flush_idle_cmds", cmd_count - c0, 0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 20);

    // Randomized traffic with bounces, back-pressure and occasional flush.
    for (int seg = 0; seg < 150; seg++) begin
      logic [3:0] sw;
      int len;
      sw  = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 30);
      for (int k = 0; k < len; k++)
        applyStimulus(sw, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 1);
    end
    applyStimulus(4'b0000, 1'b1, 1'b0, 20);

    // Button held through reset still yields a press afterwards.
    {switch4, switch3, switch2, switch1} = 4'b0001;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst2_valid", move_valid, 0);
    checkOutput("rst2_sw_state", sw_state, 0);
    reset = 1'b0;
    c0 = cmd_count;
    applyStimulus(4'b0001, 1'b1, 1'b0, 10);
    checkOutput("rst2_cmds", cmd_count - c0, 1);
    checkOutput("rst2_dir", cmd_dir, 0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
